// File: rtl/memory_pkg.sv
// Shared MEM-stage definitions: memory control encoding, data width and
// a small decoder that turns a raw control nibble into an access kind.
package memory_pkg;

    // Width of every data word moved through the MEM stage
    localparam int DATA_W = 32;

    // Bit positions inside the 4-bit memory control field
    localparam int MEM_CTRL_STORE_BIT = 3;
    localparam int MEM_CTRL_LOAD_BIT  = 2;

    // Canonical control values (low two bits are reserved and stay 00)
    localparam logic [3:0] MEM_CTRL_NONE  = 4'b0000;
    localparam logic [3:0] MEM_CTRL_LOAD  = 4'b0100;
    localparam logic [3:0] MEM_CTRL_STORE = 4'b1000;

    // What a slot actually does this cycle once precedence is resolved
    typedef enum logic [1:0] {
        ACCESS_NONE  = 2'd0,
        ACCESS_LOAD  = 2'd1,
        ACCESS_STORE = 2'd2
    } access_e;

    // A store bit always wins over a load bit; reserved bits are ignored
    function automatic access_e decode_access(input logic [3:0] mem_ctrl);
        access_e kind;
        kind = ACCESS_NONE;
        if (mem_ctrl[MEM_CTRL_STORE_BIT]) begin
            kind = ACCESS_STORE;
        end else if (mem_ctrl[MEM_CTRL_LOAD_BIT]) begin
            kind = ACCESS_LOAD;
        end
        return kind;
    endfunction

endpackage

// File: rtl/memory_mem_read_port.sv
// One combinational load port of the MEM-stage data memory.
// Slices the word address, gates the result with the load decode and,
// when forwarding is enabled, bypasses an older slot's same-cycle store.
module mem_read_port
    import memory_pkg::*;
#(
    parameter int DEPTH      = 256,
    parameter int AW         = 8,
    parameter bit FORWARD_EN = 1'b0
) (
    input  logic [DEPTH-1:0][DATA_W-1:0] mem_words,
    input  logic [DATA_W-1:0]            aluout,
    input  logic [3:0]                   mem_ctrl,
    input  logic                         fwd_store,
    input  logic [DATA_W-1:0]            fwd_addr,
    input  logic [DATA_W-1:0]            fwd_data,
    output logic [DATA_W-1:0]            readdata
);

    logic [AW-1:0] word_addr;
    logic [AW-1:0] fwd_word_addr;
    logic          is_load;
    logic          fwd_hit;
    logic          unused_addr_bits;

    // Only the low AW bits select a word, so addresses wrap modulo DEPTH
    assign word_addr        = aluout[AW-1:0];
    assign fwd_word_addr    = fwd_addr[AW-1:0];
    assign unused_addr_bits = ^{aluout[DATA_W-1:AW], fwd_addr[DATA_W-1:AW]};

    assign is_load = (decode_access(mem_ctrl) == ACCESS_LOAD);
    assign fwd_hit = FORWARD_EN && fwd_store && (fwd_word_addr == word_addr);

    // Load result: forwarded older store, else array contents, else zero
    always_comb begin
        readdata = '0;
        if (is_load) begin
            if (fwd_hit) begin
                readdata = fwd_data;
            end else begin
                readdata = mem_words[word_addr];
            end
        end
    end

endmodule

// File: rtl/memory.sv
// Two-ported word-addressed data memory for the dual-issue MEM stage.
// Synchronous writes from both slots (younger slot wins on a collision),
// combinational reads, and an asynchronous active-low clear of the array.
module memory
    import memory_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] aluout_m_0,
    input  logic [DATA_W-1:0] aluout_m_1,
    input  logic [DATA_W-1:0] upperimm_m_0,
    input  logic [DATA_W-1:0] upperimm_m_1,
    input  logic [3:0]        mem_ctrl_m_0,
    input  logic [3:0]        mem_ctrl_m_1,
    input  logic [DATA_W-1:0] writedata_m_0,
    input  logic [DATA_W-1:0] writedata_m_1,
    output logic [DATA_W-1:0] readdata_m_0,
    output logic [DATA_W-1:0] readdata_m_1
);

    logic [DEPTH-1:0][DATA_W-1:0] mem_array;

    logic [AW-1:0] write_addr_0;
    logic [AW-1:0] write_addr_1;
    logic          store_0;
    logic          store_1;
    logic          fwd_store_0;
    logic          unused_inputs;

    assign write_addr_0 = aluout_m_0[AW-1:0];
    assign write_addr_1 = aluout_m_1[AW-1:0];

    assign store_0 = (decode_access(mem_ctrl_m_0) == ACCESS_STORE);
    assign store_1 = (decode_access(mem_ctrl_m_1) == ACCESS_STORE);

    // A store issued while reset is held never lands, so it must not forward
    assign fwd_store_0 = store_0 & reset;

    // Upper immediates are reserved for future use and intentionally dropped
    assign unused_inputs = ^{upperimm_m_0, upperimm_m_1,
                             aluout_m_0[DATA_W-1:AW], aluout_m_1[DATA_W-1:AW]};

    // Array update: clear on reset, else slot 0 then slot 1 so slot 1 wins
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_array <= '0;
        end else begin
            if (store_0) begin
                mem_array[write_addr_0] <= writedata_m_0;
            end
            if (store_1) begin
                mem_array[write_addr_1] <= writedata_m_1;
            end
        end
    end

    // Slot 0 is oldest, so nothing can forward into it
    mem_read_port #(
        .DEPTH      (DEPTH),
        .AW         (AW),
        .FORWARD_EN (1'b0)
    ) u_read_port_0 (
        .mem_words (mem_array),
        .aluout    (aluout_m_0),
        .mem_ctrl  (mem_ctrl_m_0),
        .fwd_store (1'b0),
        .fwd_addr  ('0),
        .fwd_data  ('0),
        .readdata  (readdata_m_0)
    );

    // Slot 1 sees slot 0's same-cycle store to preserve program order
    mem_read_port #(
        .DEPTH      (DEPTH),
        .AW         (AW),
        .FORWARD_EN (1'b1)
    ) u_read_port_1 (
        .mem_words (mem_array),
        .aluout    (aluout_m_1),
        .mem_ctrl  (mem_ctrl_m_1),
        .fwd_store (fwd_store_0),
        .fwd_addr  (aluout_m_0),
        .fwd_data  (writedata_m_0),
        .readdata  (readdata_m_1)
    );

endmodule

// File: tb/tb_memory.sv
// Testbench for the dual-ported MEM-stage data memory: directed vector
// table, hand-written reset sequences and a randomized run against a
// simple array-based reference model.
module tb_memory;

    localparam int DEPTH = 256;
    localparam int AW    = 8;

    logic        clk;
    logic        reset;
    logic [31:0] aluout_m_0, aluout_m_1;
    logic [31:0] upperimm_m_0, upperimm_m_1;
    logic [3:0]  mem_ctrl_m_0, mem_ctrl_m_1;
    logic [31:0] writedata_m_0, writedata_m_1;
    logic [31:0] readdata_m_0, readdata_m_1;

    typedef struct {
        logic [3:0]  c0;
        logic [31:0] a0;
        logic [31:0] w0;
        logic [3:0]  c1;
        logic [31:0] a1;
        logic [31:0] w1;
        logic [31:0] e0;
        logic [31:0] e1;
    } vec_t;

    vec_t        vecs [17];
    logic [31:0] model [DEPTH];
    int          checks;
    int          errors;

    memory #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk           (clk),
        .reset         (reset),
        .aluout_m_0    (aluout_m_0),
        .aluout_m_1    (aluout_m_1),
        .upperimm_m_0  (upperimm_m_0),
        .upperimm_m_1  (upperimm_m_1),
        .mem_ctrl_m_0  (mem_ctrl_m_0),
        .mem_ctrl_m_1  (mem_ctrl_m_1),
        .writedata_m_0 (writedata_m_0),
        .writedata_m_1 (writedata_m_1),
        .readdata_m_0  (readdata_m_0),
        .readdata_m_1  (readdata_m_1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [3:0] c0, input logic [31:0] a0, input logic [31:0] w0,
                                input logic [3:0] c1, input logic [31:0] a1, input logic [31:0] w1,
                                input logic [31:0] e0, input logic [31:0] e1);
        vec_t v;
        v.c0 = c0; v.a0 = a0; v.w0 = w0;
        v.c1 = c1; v.a1 = a1; v.w1 = w1;
        v.e0 = e0; v.e1 = e1;
        return v;
    endfunction

    task automatic applyStimulus(input logic [3:0] c0, input logic [31:0] a0, input logic [31:0] w0,
                                 input logic [3:0] c1, input logic [31:0] a1, input logic [31:0] w1);
        mem_ctrl_m_0  = c0;
        aluout_m_0    = a0;
        writedata_m_0 = w0;
        mem_ctrl_m_1  = c1;
        aluout_m_1    = a1;
        writedata_m_1 = w1;
        upperimm_m_0  = $urandom;
        upperimm_m_1  = $urandom;
        #2;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Reference rules: store beats load, slot 1 sees slot 0's store,
    // slot 0 never sees slot 1's store, reset hides everything.
    task automatic predict(output logic [31:0] exp0, output logic [31:0] exp1);
        int i0, i1;
        bit st0, ld0, ld1;
        i0  = int'(aluout_m_0 % DEPTH);
        i1  = int'(aluout_m_1 % DEPTH);
        st0 = mem_ctrl_m_0[3];
        ld0 = mem_ctrl_m_0[2] && !mem_ctrl_m_0[3];
        ld1 = mem_ctrl_m_1[2] && !mem_ctrl_m_1[3];
        exp0 = 32'h0;
        exp1 = 32'h0;
        if (reset) begin
            if (ld0) exp0 = model[i0];
            if (ld1) exp1 = (st0 && i0 == i1) ? writedata_m_0 : model[i1];
        end
    endtask

    // Clock one edge and apply the current stores to the model in program order
    task automatic commitEdge();
        @(posedge clk);
        if (reset) begin
            if (mem_ctrl_m_0[3]) model[int'(aluout_m_0 % DEPTH)] = writedata_m_0;
            if (mem_ctrl_m_1[3]) model[int'(aluout_m_1 % DEPTH)] = writedata_m_1;
        end
        @(negedge clk);
    endtask

    task automatic clearModel();
        for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
    endtask

    initial begin
        logic [31:0] exp0, exp1;
        logic [3:0]  kinds [4];
        checks = 0;
        errors = 0;
        kinds[0] = 4'b0000; kinds[1] = 4'b0100; kinds[2] = 4'b1000; kinds[3] = 4'b1100;

        vecs[0]  = mk(4'b0100, 32'd10,  32'd0,    4'b0100, 32'd20,  32'd0,  32'd0,    32'd0);
        vecs[1]  = mk(4'b1000, 32'd10,  32'd30,   4'b0000, 32'd0,   32'd0,  32'd0,    32'd0);
        vecs[2]  = mk(4'b0100, 32'd10,  32'd0,    4'b0000, 32'd10,  32'd0,  32'd30,   32'd0);
        vecs[3]  = mk(4'b0000, 32'd0,   32'd0,    4'b1000, 32'd70,  32'd80, 32'd0,    32'd0);
        vecs[4]  = mk(4'b0000, 32'd70,  32'd0,    4'b0100, 32'd70,  32'd0,  32'd0,    32'd80);
        vecs[5]  = mk(4'b0100, 32'd326, 32'd0,    4'b0100, 32'd70,  32'd0,  32'd80,   32'd80);
        vecs[6]  = mk(4'b1000, 32'd3,   32'd2,    4'b1000, 32'd1,   32'd4,  32'd0,    32'd0);
        vecs[7]  = mk(4'b0100, 32'd3,   32'd0,    4'b0100, 32'd1,   32'd0,  32'd2,    32'd4);
        vecs[8]  = mk(4'b0100, 32'd100, 32'd0,    4'b0100, 32'd12,  32'd0,  32'd0,    32'd0);
        vecs[9]  = mk(4'b1000, 32'd5,   32'd11,   4'b1000, 32'd5,   32'd22, 32'd0,    32'd0);
        vecs[10] = mk(4'b0100, 32'd5,   32'd0,    4'b0100, 32'd5,   32'd0,  32'd22,   32'd22);
        vecs[11] = mk(4'b1000, 32'd9,   32'hAB,   4'b0100, 32'd9,   32'd0,  32'd0,    32'hAB);
        vecs[12] = mk(4'b0100, 32'd9,   32'd0,    4'b1100, 32'd200, 32'd7,  32'hAB,   32'd0);
        vecs[13] = mk(4'b0100, 32'd200, 32'd0,    4'b0100, 32'd200, 32'd0,  32'd7,    32'd7);
        vecs[14] = mk(4'b0100, 32'd40,  32'd0,    4'b1000, 32'd40,  32'd55, 32'd0,    32'd0);
        vecs[15] = mk(4'b0100, 32'd40,  32'd0,    4'b0000, 32'd0,   32'd0,  32'd55,   32'd0);
        vecs[16] = mk(4'b0111, 32'd10,  32'd0,    4'b0000, 32'd0,   32'd0,  32'd30,   32'd0);

        // Power-on reset held for two cycles with loads pending
        reset = 1'b0;
        clearModel();
        applyStimulus(4'b0100, 32'd10, 32'd0, 4'b0100, 32'd20, 32'd0);
        @(negedge clk);
        @(negedge clk);
        #2;
        checkOutput("reset_load_slot0", readdata_m_0, 32'h0);
        checkOutput("reset_load_slot1", readdata_m_1, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // Directed vector table
        for (int i = 0; i < 17; i++) begin
            applyStimulus(vecs[i].c0, vecs[i].a0, vecs[i].w0, vecs[i].c1, vecs[i].a1, vecs[i].w1);
            checkOutput($sformatf("vec%0d_slot0", i), readdata_m_0, vecs[i].e0);
            checkOutput($sformatf("vec%0d_slot1", i), readdata_m_1, vecs[i].e1);
            commitEdge();
        end

        // Mid-run asynchronous reset between edges
        applyStimulus(4'b0100, 32'd10, 32'd0, 4'b0100, 32'd70, 32'd0);
        checkOutput("pre_reset_10", readdata_m_0, 32'd30);
        checkOutput("pre_reset_70", readdata_m_1, 32'd80);
        reset = 1'b0;
        #1;
        checkOutput("async_reset_10", readdata_m_0, 32'h0);
        checkOutput("async_reset_70", readdata_m_1, 32'h0);
        clearModel();
        mem_ctrl_m_0  = 4'b1000;
        writedata_m_0 = 32'h55;
        #1;
        checkOutput("reset_no_forward", readdata_m_1, 32'h0);
        commitEdge();
        reset = 1'b1;
        applyStimulus(4'b0100, 32'd10, 32'd0, 4'b0100, 32'd70, 32'd0);
        checkOutput("lost_store_10", readdata_m_0, 32'h0);
        checkOutput("cleared_70", readdata_m_1, 32'h0);
        commitEdge();

        // Randomized traffic over a small address window to force collisions
        for (int n = 0; n < 400; n++) begin
            logic [31:0] a0, a1;
            logic [3:0]  c0, c1;
            a0 = {$urandom_range(0, 3), 24'h0, 8'($urandom_range(0, 15))};
            a1 = {$urandom_range(0, 3), 24'h0, 8'($urandom_range(0, 15))};
            c0 = kinds[$urandom_range(0, 3)];
            c1 = kinds[$urandom_range(0, 3)];
            if ($urandom_range(0, 7) == 0) c0[1:0] = 2'($urandom_range(0, 3));
            applyStimulus(c0, a0, $urandom, c1, a1, $urandom);
            predict(exp0, exp1);
            checkOutput($sformatf("rand%0d_slot0", n), readdata_m_0, exp0);
            checkOutput($sformatf("rand%0d_slot1", n), readdata_m_1, exp1);
            commitEdge();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
